// File: rtl/bram_1rw_pkg.sv
// Shared types and constants for the 1RW SRAM request front end.
package bram_1rw_pkg;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int RSP_FIFO_DEPTH = 2;

endpackage

// File: rtl/bram_rsp_fifo.sv
// Two-entry in-order read-response buffer; push and pop may coincide at any occupancy.
module bram_rsp_fifo
   import bram_1rw_pkg::*;
#(
   parameter int DATA_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic [1:0]            count
);

   logic [DATA_WIDTH-1:0] store [RSP_FIFO_DEPTH];
   logic                  wr_ptr;
   logic                  rd_ptr;

   // When full, the slot being pushed is the one being popped this cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
            store[i] <= '0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            store[wr_ptr] <= push_data;
            wr_ptr        <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + 2'(push) - 2'(pop);
      end
   end

   assign head_data = store[rd_ptr];

endmodule

// File: rtl/bram_1rw_req_ctrl.sv
// Valid/ready request front end for the 1RW SRAM wrapper: optional zero-fill sweep,
// one-cycle read tracking and a 2-entry response buffer.
module bram_1rw_req_ctrl
   import bram_1rw_pkg::*;
#(
   parameter int DEPTH         = 1,
   parameter int ADDR_WIDTH    = 1,
   parameter int DATA_WIDTH    = 1,
   parameter int BITMASK_WIDTH = 1,
   parameter int INIT_ZERO     = 1
) (
   input  logic                     MEMCLK,
   input  logic                     RESET,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [ADDR_WIDTH-1:0]    req_addr,
   input  logic [BITMASK_WIDTH-1:0] req_wmask,
   input  logic [DATA_WIDTH-1:0]    req_wdata,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_WIDTH-1:0]    rsp_rdata,
   output logic                     init_done,
   output logic                     mem_ce,
   output logic                     mem_rdwen,
   output logic [ADDR_WIDTH-1:0]    mem_a,
   output logic [BITMASK_WIDTH-1:0] mem_bw,
   output logic [DATA_WIDTH-1:0]    mem_din,
   input  logic [DATA_WIDTH-1:0]    mem_dout
);

   // Handshake: a request transfers on a rising MEMCLK edge where req_valid & req_ready;
   // a response transfers where rsp_valid & rsp_ready. Neither side may retract
   // expectations on the other, and req_ready may depend on rsp_ready and req_we.

   state_t                  state;
   state_t                  state_nxt;
   logic [ADDR_WIDTH-1:0]   init_cnt;
   logic                    last_addr;
   logic                    inflight;
   logic [1:0]              fifo_count;
   logic                    rsp_pop;
   logic                    read_room;
   logic                    accept;
   logic                    read_accept;

   assign last_addr = (init_cnt == ADDR_WIDTH'(DEPTH - 1));

   always_ff @(posedge MEMCLK or posedge RESET) begin
      if (RESET) begin
         state <= ST_INIT;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge MEMCLK or posedge RESET) begin
      if (RESET) begin
         init_cnt <= '0;
      end else if (INIT_ZERO != 0 && state == ST_INIT && !last_addr) begin
         init_cnt <= init_cnt + 1'b1;
      end
   end

   // The macro returns data one cycle after a read issue; that is the only cycle
   // mem_dout is captured.
   always_ff @(posedge MEMCLK or posedge RESET) begin
      if (RESET) begin
         inflight <= 1'b0;
      end else begin
         inflight <= read_accept;
      end
   end

   bram_rsp_fifo #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rsp_fifo (
      .clk       (MEMCLK),
      .rst       (RESET),
      .push      (inflight),
      .push_data (mem_dout),
      .pop       (rsp_pop),
      .head_data (rsp_rdata),
      .count     (fifo_count)
   );

   assign rsp_valid = (fifo_count != 2'd0);
   assign rsp_pop   = rsp_valid & rsp_ready;
   assign init_done = (state == ST_RUN);

   // A read needs a slot for itself once the buffered and in-flight data are counted.
   assign read_room   = (3'(fifo_count) + 3'(inflight) - 3'(rsp_pop)) < 3'(RSP_FIFO_DEPTH);
   assign req_ready   = (state == ST_RUN) & (req_we | read_room);
   assign accept      = req_valid & req_ready;
   assign read_accept = accept & ~req_we;

   always_comb begin
      state_nxt = state;
      mem_ce    = 1'b0;
      mem_rdwen = 1'b1;
      mem_a     = '0;
      mem_bw    = '0;
      mem_din   = '0;
      unique case (state)
         ST_INIT: begin
            if (INIT_ZERO == 0 || last_addr) begin
               state_nxt = ST_RUN;
            end
            if (INIT_ZERO != 0) begin
               mem_ce    = 1'b1;
               mem_rdwen = 1'b0;
               mem_a     = init_cnt;
               mem_bw    = '1;
            end
         end
         ST_RUN: begin
            mem_ce    = accept;
            mem_rdwen = ~(accept & req_we);
            mem_a     = req_addr;
            mem_bw    = req_wmask;
            mem_din   = req_wdata;
         end
         default: state_nxt = ST_INIT;
      endcase
      // Pins idle the moment reset asserts, without waiting for a clock edge.
      if (RESET) begin
         state_nxt = ST_INIT;
         mem_ce    = 1'b0;
         mem_rdwen = 1'b1;
         mem_a     = '0;
         mem_bw    = '0;
         mem_din   = '0;
      end
   end

endmodule

// File: tb/tb_bram_1rw_req_ctrl.sv
// Directed bench for bram_1rw_req_ctrl with a behavioural 1RW macro and a response scoreboard.
module tb_bram_1rw_req_ctrl;

   localparam int DEPTH = 512;
   localparam int AW    = 9;
   localparam int DW    = 32;

   logic          MEMCLK = 1'b0;
   logic          RESET;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wmask;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          init_done;
   logic          mem_ce;
   logic          mem_rdwen;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] mem_bw;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;

   int            checks   = 0;
   int            failures = 0;
   int            cycle    = 0;
   logic          scramble = 1'b0;
   logic [DW-1:0] exp_q[$];
   int            pop_cyc[$];
   logic [DW-1:0] sram [DEPTH];

   bram_1rw_req_ctrl #(
      .DEPTH         (DEPTH),
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .BITMASK_WIDTH (DW),
      .INIT_ZERO     (1)
   ) dut (
      .MEMCLK    (MEMCLK),
      .RESET     (RESET),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wmask (req_wmask),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .init_done (init_done),
      .mem_ce    (mem_ce),
      .mem_rdwen (mem_rdwen),
      .mem_a     (mem_a),
      .mem_bw    (mem_bw),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout)
   );

   // ---------------- clock / reset ----------------
   always #5 MEMCLK = ~MEMCLK;

   always @(posedge MEMCLK) cycle <= cycle + 1;

   // Behavioural 1RW macro: bit-masked write, registered read data.
   always @(posedge MEMCLK) begin
      if (scramble) begin
         for (int i = 0; i < DEPTH; i++) sram[i] <= $urandom();
      end else if (mem_ce) begin
         if (!mem_rdwen) sram[mem_a] <= (sram[mem_a] & ~mem_bw) | (mem_din & mem_bw);
         else            mem_dout    <= sram[mem_a];
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cycle);
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   initial begin
      logic [DW-1:0] e;
      forever begin
         @(negedge MEMCLK);
         if (RESET === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            pop_cyc.push_back(cycle);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rsp_unexpected got=%h exp=none", rsp_rdata);
            end else begin
               e = exp_q.pop_front();
               check("rsp_rdata", rsp_rdata, e);
            end
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic idle();
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wmask = '0;
      req_wdata = '0;
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] mask,
                        input logic [DW-1:0] data, input logic [DW-1:0] exp,
                        output int waited, output int acc_cyc);
      logic exp_rdwen;
      exp_rdwen = !we;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wmask = mask;
      req_wdata = data;
      waited    = 0;
      acc_cyc   = -1;
      forever begin
         @(negedge MEMCLK);
         if (req_ready === 1'b1) break;
         waited++;
         if (waited >= 40) begin
            checks++;
            failures++;
            $display("FAIL req_ready_timeout got=0 exp=1 addr=%0d", addr);
            @(posedge MEMCLK);
            #1;
            idle();
            return;
         end
      end
      check("issue_ce", mem_ce, 1'b1);
      check("issue_rdwen", mem_rdwen, exp_rdwen);
      check("issue_addr", mem_a, addr);
      @(posedge MEMCLK);
      if (!we) exp_q.push_back(exp);
      #1;
      acc_cyc = cycle;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge MEMCLK);
      #1;
   endtask

   // Called at posedge+1 just after reset release; returns at posedge+1 in ST_RUN.
   task automatic sweep_check();
      int bad;
      bad = 0;
      for (int k = 0; k < DEPTH; k++) begin
         @(negedge MEMCLK);
         if (!(mem_ce === 1'b1 && mem_rdwen === 1'b0 && mem_a === AW'(k) && mem_bw === 32'hFFFF_FFFF &&
               mem_din === 32'h0 && req_ready === 1'b0 && init_done === 1'b0)) begin
            bad++;
         end
      end
      check("sweep_bad_cycles", bad, 0);
      @(negedge MEMCLK);
      check("init_done_rise", init_done, 1'b1);
      @(posedge MEMCLK);
      #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int w, c, c0, c1, n0;
      RESET     = 1'b1;
      rsp_ready = 1'b0;
      idle();
      scramble  = 1'b1;
      wait_cycles(2);
      scramble  = 1'b0;

      @(negedge MEMCLK);
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_init_done", init_done, 1'b0);
      check("rst_mem_ce", mem_ce, 1'b0);
      check("rst_mem_rdwen", mem_rdwen, 1'b1);
      check("rst_mem_a", mem_a, 9'd0);
      check("rst_mem_bw", mem_bw, 32'h0);
      check("rst_mem_din", mem_din, 32'h0);

      @(posedge MEMCLK);
      #1;
      RESET = 1'b0;
      sweep_check();
      rsp_ready = 1'b1;

      // full write then read with latency check
      issue(1'b1, 9'd5, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0, w, c);
      issue(1'b0, 9'd5, 32'h0, 32'h0, 32'hDEAD_BEEF, w, c);
      idle();
      @(negedge MEMCLK);
      check("rd_lat_early", rsp_valid, 1'b0);
      @(negedge MEMCLK);
      check("rd_lat_valid", rsp_valid, 1'b1);
      @(posedge MEMCLK);
      #1;

      // masked write
      issue(1'b1, 9'd5, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0, w, c);
      issue(1'b0, 9'd5, 32'h0, 32'h0, 32'hFFFF_BEEF, w, c);
      issue(1'b0, 9'd6, 32'h0, 32'h0, 32'h0000_0000, w, c);
      idle();
      wait_cycles(4);

      // backpressure: two reads outstanding, third stalls, writes pass
      issue(1'b1, 9'd1, 32'hFFFF_FFFF, 32'h1111_1111, 32'h0, w, c);
      issue(1'b1, 9'd2, 32'hFFFF_FFFF, 32'h2222_2222, 32'h0, w, c);
      issue(1'b1, 9'd3, 32'hFFFF_FFFF, 32'h3333_3333, 32'h0, w, c);
      rsp_ready = 1'b0;
      issue(1'b0, 9'd1, 32'h0, 32'h0, 32'h1111_1111, w, c);
      check("bp_rd1_wait", w, 0);
      issue(1'b0, 9'd2, 32'h0, 32'h0, 32'h2222_2222, w, c);
      check("bp_rd2_wait", w, 0);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 9'd3;
      n0 = 0;
      repeat (3) begin
         @(negedge MEMCLK);
         if (req_ready !== 1'b0) n0++;
      end
      check("bp_rd3_stall", n0, 0);
      @(posedge MEMCLK);
      #1;
      issue(1'b1, 9'd7, 32'hFFFF_FFFF, 32'h7777_7777, 32'h0, w, c);
      check("bp_wr7_wait", w, 0);
      rsp_ready = 1'b1;
      issue(1'b0, 9'd3, 32'h0, 32'h0, 32'h3333_3333, w, c);
      check("bp_rd3_first_pop", w, 0);
      issue(1'b0, 9'd7, 32'h0, 32'h0, 32'h7777_7777, w, c);
      idle();
      wait_cycles(5);
      check("bp_drain_empty", exp_q.size(), 0);

      // throughput: 8 back-to-back reads
      issue(1'b0, 9'd0, 32'h0, 32'h0, 32'h0000_0000, w, c0);
      issue(1'b0, 9'd1, 32'h0, 32'h0, 32'h1111_1111, w, c);
      issue(1'b0, 9'd2, 32'h0, 32'h0, 32'h2222_2222, w, c);
      issue(1'b0, 9'd3, 32'h0, 32'h0, 32'h3333_3333, w, c);
      issue(1'b0, 9'd4, 32'h0, 32'h0, 32'h0000_0000, w, c);
      issue(1'b0, 9'd5, 32'h0, 32'h0, 32'hFFFF_BEEF, w, c);
      issue(1'b0, 9'd6, 32'h0, 32'h0, 32'h0000_0000, w, c);
      issue(1'b0, 9'd7, 32'h0, 32'h0, 32'h7777_7777, w, c1);
      idle();
      wait_cycles(5);
      check("thru_accept_span", c1 - c0, 7);
      if (pop_cyc.size() >= 8) begin
         check("thru_rsp_span", pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-8], 7);
      end else begin
         check("thru_rsp_count", pop_cyc.size(), 8);
      end
      check("thru_drain_empty", exp_q.size(), 0);

      // reset with two responses buffered
      rsp_ready = 1'b0;
      issue(1'b0, 9'd1, 32'h0, 32'h0, 32'h1111_1111, w, c);
      issue(1'b0, 9'd2, 32'h0, 32'h0, 32'h2222_2222, w, c);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 9'd9;
      req_wmask = 32'hFFFF_FFFF;
      req_wdata = 32'h9999_9999;
      wait_cycles(2);
      @(negedge MEMCLK);
      check("pre_rst_rsp_valid", rsp_valid, 1'b1);
      check("pre_rst_mem_ce", mem_ce, 1'b1);
      #2;
      RESET = 1'b1;
      #1;
      check("mid_rst_rsp_valid", rsp_valid, 1'b0);
      check("mid_rst_req_ready", req_ready, 1'b0);
      check("mid_rst_init_done", init_done, 1'b0);
      check("mid_rst_mem_ce", mem_ce, 1'b0);
      exp_q.delete();
      idle();
      rsp_ready = 1'b1;
      wait_cycles(2);
      RESET = 1'b0;
      sweep_check();
      wait_cycles(4);
      issue(1'b0, 9'd1, 32'h0, 32'h0, 32'h0000_0000, w, c);
      issue(1'b0, 9'd9, 32'h0, 32'h0, 32'h0000_0000, w, c);
      idle();
      wait_cycles(5);
      check("post_rst_drain_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bram_1rw_req_ctrl.md
# bram_1rw_req_ctrl

Request front end for the single-port (1RW) SRAM macro wrapper. Accepts read/write requests on a valid/ready interface and drives the wrapper's CE/A/RDWEN/BW/DIN pins. Tracks the one-cycle read latency and buffers read data in a 2-entry response FIFO, so data is never lost under backpressure. After reset it optionally zero-fills the whole array before accepting traffic.

## Interface
Parameters:
- DEPTH, 1 — number of words; the init sweep covers 0..DEPTH-1
- ADDR_WIDTH, 1 — address width; DEPTH ≤ 2^ADDR_WIDTH
- DATA_WIDTH, 1 — word width
- BITMASK_WIDTH, 1 — write-mask width; equals DATA_WIDTH; bit=1 writes that bit
- INIT_ZERO, 1 — 1: zero-fill the array after reset; 0: skip the sweep

Ports:
- MEMCLK  in  1  clock
- RESET  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid & ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wmask  in  BITMASK_WIDTH  per-bit write enable
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer takes the read data
- rsp_rdata  out  DATA_WIDTH  read data, in request order
- init_done  out  1  sweep finished; requests allowed
- mem_ce, mem_rdwen  out  1 each  to wrapper CE, RDWEN (0 = write)
- mem_a  out  ADDR_WIDTH  to wrapper A
- mem_bw  out  BITMASK_WIDTH  to wrapper BW
- mem_din  out  DATA_WIDTH  to wrapper DIN
- mem_dout  in  DATA_WIDTH  from wrapper DOUT

## Operation
- State machine: ST_INIT → ST_RUN. ST_INIT is entered on reset. With INIT_ZERO=0 the block moves to ST_RUN on the first clock edge after reset release.
- ST_INIT sweep:
  - init counter runs 0..DEPTH-1, one address per cycle
  - each cycle: mem_ce=1, mem_rdwen=0, mem_bw=all ones, mem_din=0, mem_a=counter
  - transition to ST_RUN after the write to DEPTH-1; the counter never wraps past DEPTH-1
  - req_ready=0 throughout
- ST_RUN:
  - mem_* is driven combinationally from the accepted request: mem_ce = req_valid & req_ready, mem_rdwen = ~req_we, mem_a/mem_bw/mem_din = req_addr/req_wmask/req_wdata
  - when no request is accepted: mem_ce=0, mem_rdwen=1
- Writes: req_ready=1 in ST_RUN regardless of FIFO state. Writes produce no response.
- Reads:
  - req_ready = (fifo_count + inflight − pop) < 2, where pop = rsp_valid & rsp_ready
  - this leaves a combinational path rsp_ready → req_ready, which is intended
  - accepting a read sets the inflight flag
  - in the next cycle mem_dout is pushed into the FIFO and inflight clears, unless a new read is accepted in that same cycle
- mem_dout is sampled only in the cycle after a read issue; at all other times it is ignored.
- FIFO: 2 entries, in-order. rsp_valid = FIFO non-empty; rsp_rdata = head entry. Simultaneous push and pop are allowed at any occupancy.
- init_done = 1 exactly when in ST_RUN.
- Reset mid-operation:
  - RESET assertion immediately clears the FIFO, inflight, the counter and init_done, and forces state to ST_INIT
  - buffered and in-flight responses are discarded
  - the sweep restarts at address 0 after reset release

## Timing
- Reset values of all outputs: req_ready 0, rsp_valid 0, rsp_rdata 0, init_done 0, mem_ce 0, mem_rdwen 1, mem_a 0, mem_bw 0, mem_din 0.
- Sweep length: DEPTH cycles. init_done rises on the edge after the last sweep write, i.e. DEPTH cycles after reset release.
- Read latency: read accepted at edge N → rsp_valid=1 in the cycle after edge N+1. This is one registered stage after the macro's one-cycle latency.
- Throughput:
  - with rsp_ready held 1, one read or write per cycle, back-to-back
  - with rsp_ready=0, at most 2 reads are outstanding (FIFO plus in-flight); further reads stall, writes still pass

## Structure
- Package bram_1rw_pkg holds:
  - typedef for the state enum (ST_INIT, ST_RUN)
  - constant RSP_FIFO_DEPTH = 2
- Sub-module bram_rsp_fifo: 2-entry, DATA_WIDTH-wide synchronous FIFO with count output and asynchronous active-high reset.
- The top level contains the state machine, init counter, inflight flag and mem_* muxing.
- Instantiated directly upstream of bram_1rw_wrapper; the mem_* ports connect one-to-one to its pins.

## Test plan
All scenarios use DEPTH=512, ADDR_WIDTH=9, DATA_WIDTH=BITMASK_WIDTH=32.
- Reset release with INIT_ZERO=1 → 512 consecutive writes at addresses 0..511 with mem_bw=0xFFFFFFFF and mem_din=0; init_done rises 512 cycles after release; req_ready stays 0 until then.
- Write 0xDEADBEEF to address 5 with mask 0xFFFFFFFF, then read address 5 → rsp_rdata=0xDEADBEEF, rsp_valid one cycle after the macro read.
- Write 0xFFFF0000 to address 5 with mask 0xFFFF0000, then read address 5 → 0xFFFFBEEF. A read of address 6 returns 0x00000000.
- With rsp_ready=0, reads of addresses 1, 2, 3 presented back-to-back → 1 and 2 accepted, req_ready=0 for 3. A write to address 7 is still accepted meanwhile. Raising rsp_ready → responses for 1 and 2 in order; read 3 accepted in the first pop cycle; no data lost or duplicated.
- With rsp_ready=1, reads of addresses 0..7 back-to-back → 8 accepts in 8 cycles and 8 consecutive rsp_valid cycles, data in address order.
- Assert RESET with 2 responses buffered → rsp_valid, req_ready, init_done and mem_ce drop without waiting for a clock edge. After release the sweep restarts at address 0 and the old responses never appear.
